// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the checkerboard BIST response side.
//   - state_e      : fail-log controller state encoding
//                    (IDLE=0, CAPTURE=1, DRAIN=2, DONE=3)
//   - BIST_ADDR_W  : default SRAM address width
//   - BIST_DATA_W  : default SRAM word width
// Log-entry packing: an entry is {addr, syndrome}, with the address in the
// upper ADDR_W bits and the failing-bit syndrome in the lower DATA_W bits.
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int BIST_ADDR_W = 4;
  localparam int BIST_DATA_W = 2;

endpackage

// File: rtl/bist_fail_fifo.sv
// -----------------------------------------------------------------------------
// bist_fail_fifo
// Small in-order log buffer for fail entries.
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset (pointers only)
//   flush_i      : synchronous clear of all entries
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : head entry, read straight from the storage registers
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   one_left_o   : exactly one entry held
// Pointers carry one extra wrap bit so full and empty are distinguishable
// when the index bits are equal.
// -----------------------------------------------------------------------------
module bist_fail_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             one_left_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   used;
  logic             do_push;
  logic             do_pop;

  assign used       = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign one_left_o = (used == (PTR_W+1)'(1));
  assign head_o     = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/bist_cb_fail_log.sv
// -----------------------------------------------------------------------------
// bist_cb_fail_log
// Captures every mismatching BIST compare as {address, syndrome} into a small
// FIFO log, counts all mismatches (saturating) and flags dropped entries, then
// drains the log to the tester once the test has ended.
// Ports:
//   clk, rst_n (async, active-high reset despite its name)
//   start                        : restart capture, clears log and counters
//   cmp_valid/addr/expect/actual : compare strobe from the BIST engine
//   test_done                    : end of test marker
//   log_valid/ready/addr/syn     : drain handshake and head entry
//   fail_cnt, overflow           : mismatch count, dropped-entry flag
//   done, pass                   : drain finished, finished with no fails
//   dbg_state                    : current controller state (state_e)
// Handshake: an entry transfers on each rising edge where log_valid and
// log_ready are both high; while log_valid is high and log_ready low the
// presented log_addr/log_syn hold steady, and log_valid never drops without
// a transfer except on start or reset.
// -----------------------------------------------------------------------------
module bist_cb_fail_log
  import bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] cmp_expect,
  input  logic [DATA_W-1:0] cmp_actual,
  input  logic              test_done,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_syn,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              overflow,
  output logic              done,
  output logic              pass,
  output logic [1:0]        dbg_state
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               overflow_q, overflow_d;

  logic               mismatch;
  logic               in_capture;
  logic               in_drain;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_one_left;
  logic [ENTRY_W-1:0] fifo_head;

  assign mismatch   = cmp_valid && (cmp_expect != cmp_actual);
  assign in_capture = (state_q == ST_CAPTURE);
  assign in_drain   = (state_q == ST_DRAIN);

  // start overrides everything in the same cycle: no capture, no pop.
  assign fifo_push = in_capture && mismatch && !fifo_full && !start;
  assign fifo_pop  = in_drain && !fifo_empty && log_ready && !start;

  bist_fail_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .flush_i     (start),
    .push_i      (fifo_push),
    .push_data_i ({cmp_addr, cmp_expect ^ cmp_actual}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .one_left_o  (fifo_one_left)
  );

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    overflow_d = overflow_q;
    if (start) begin
      state_d    = ST_CAPTURE;
      fail_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (mismatch) begin
            if (fail_cnt_q != {CNT_W{1'b1}})
              fail_cnt_d = fail_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (fifo_full) overflow_d = 1'b1;
          end
          if (test_done) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Leave on the edge that pops the last entry so done rises
          // together with log_valid falling.
          if (fifo_empty || (fifo_pop && fifo_one_left)) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      fail_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Head fields are masked when not presented so idle/reset outputs are 0.
  assign log_valid = in_drain && !fifo_empty;
  assign log_addr  = log_valid ? fifo_head[ENTRY_W-1:DATA_W] : '0;
  assign log_syn   = log_valid ? fifo_head[DATA_W-1:0] : '0;
  assign fail_cnt  = fail_cnt_q;
  assign overflow  = overflow_q;
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (fail_cnt_q == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bist_cb_fail_log.sv
// -----------------------------------------------------------------------------
// tb_bist_cb_fail_log
// Directed and randomized checks of the fail log against a queue-based model:
// every mismatch goes to exp_q while it holds fewer than DEPTH entries, the
// count saturates at 255, and the drain must reproduce exp_q in order.
// -----------------------------------------------------------------------------
module tb_bist_cb_fail_log;

  localparam int AW      = 4;
  localparam int DW      = 2;
  localparam int DEPTH   = 4;
  localparam int CW      = 8;
  localparam int ENTRY_W = AW + DW;
  localparam int CNT_MAX = 255;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          cmp_valid = 1'b0;
  logic [AW-1:0] cmp_addr = '0;
  logic [DW-1:0] cmp_expect = '0;
  logic [DW-1:0] cmp_actual = '0;
  logic          test_done = 1'b0;
  logic          log_ready = 1'b0;
  logic          log_valid;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_syn;
  logic [CW-1:0] fail_cnt;
  logic          overflow;
  logic          done;
  logic          pass;
  logic [1:0]    dbg_state;

  bist_cb_fail_log #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cmp_valid  (cmp_valid),
    .cmp_addr   (cmp_addr),
    .cmp_expect (cmp_expect),
    .cmp_actual (cmp_actual),
    .test_done  (test_done),
    .log_valid  (log_valid),
    .log_ready  (log_ready),
    .log_addr   (log_addr),
    .log_syn    (log_syn),
    .fail_cnt   (fail_cnt),
    .overflow   (overflow),
    .done       (done),
    .pass       (pass),
    .dbg_state  (dbg_state)
  );

  // scoreboard / reference model
  logic [ENTRY_W-1:0] exp_q[$];
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, log_valid, 0);
    chk({tag, "_addr"}, log_addr, 0);
    chk({tag, "_syn"}, log_syn, 0);
    chk({tag, "_cnt"}, fail_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // driver tasks
  task automatic start_pulse();
    start = 1'b1;
    cmp_valid = 1'b0;
    test_done = 1'b0;
    step();
    start = 1'b0;
    model_clear();
    chk("start_state", dbg_state, 1);
    chk("start_cnt", fail_cnt, 0);
    chk("start_ovf", overflow, 0);
    chk("start_valid", log_valid, 0);
  endtask

  task automatic cmp_cycle(input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] e, input logic [DW-1:0] act,
                           input logic td);
    cmp_valid = v;
    cmp_addr = a;
    cmp_expect = e;
    cmp_actual = act;
    test_done = td;
    step();
    cmp_valid = 1'b0;
    test_done = 1'b0;
    if (v && (e != act)) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (exp_q.size() < DEPTH) exp_q.push_back({a, e ^ act});
      else m_ovf = 1'b1;
    end
    chk("cap_cnt", fail_cnt, m_cnt);
    chk("cap_ovf", overflow, m_ovf);
    if (!td) chk("cap_valid", log_valid, 0);
  endtask

  // mode 0: ready always high, 1: low for the first 3 cycles, 2: random
  task automatic drain_run(input int mode);
    bit prev_drain;
    bit fin;
    bit rdy;
    bit pop;
    bit done_exp;
    logic [ENTRY_W-1:0] head;
    prev_drain = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      // Done once the log is empty, but never in the very cycle DRAIN is entered.
      done_exp = prev_drain && (exp_q.size() == 0);
      chk("drain_valid", log_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("drain_addr", log_addr, head[ENTRY_W-1:DW]);
        chk("drain_syn", log_syn, head[DW-1:0]);
      end
      chk("drain_done", done, done_exp);
      if (done_exp) begin
        chk("final_pass", pass, m_cnt == 0);
        chk("final_cnt", fail_cnt, m_cnt);
        chk("final_ovf", overflow, m_ovf);
        chk("final_state", dbg_state, 3);
        fin = 1'b1;
      end else begin
        case (mode)
          0: rdy = 1'b1;
          1: rdy = (i >= 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        log_ready = rdy;
        // Compares outside CAPTURE must be ignored.
        cmp_valid = 1'($urandom_range(0, 1));
        cmp_addr = AW'($urandom_range(0, 15));
        cmp_expect = 2'b01;
        cmp_actual = 2'b10;
        pop = rdy && (exp_q.size() != 0);
        step();
        if (pop) void'(exp_q.pop_front());
        prev_drain = 1'b1;
      end
    end
    chk("drain_timeout", fin, 1);
    log_ready = 1'b0;
    cmp_valid = 1'b0;
  endtask

  task automatic two_fault_run(input int mode);
    start_pulse();
    cmp_cycle(1'b1, 4'd3, 2'b01, 2'b11, 1'b0);
    cmp_cycle(1'b1, 4'd5, 2'b10, 2'b10, 1'b0);
    cmp_cycle(1'b1, 4'd9, 2'b10, 2'b00, 1'b0);
    cmp_cycle(1'b0, 4'd0, 2'b00, 2'b00, 1'b1);
    drain_run(mode);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    logic [DW-1:0] act;
    logic v;
    int n;

    // reset state
    rst_n = 1'b1;
    step();
    chk_all_zero("rst_held");
    cmp_valid = 1'b1;
    cmp_expect = 2'b01;
    cmp_actual = 2'b10;
    step();
    rst_n = 1'b0;
    step();
    cmp_valid = 1'b0;
    chk_all_zero("idle");

    // clean run: 16 matching compares
    start_pulse();
    for (int i = 0; i < 16; i++) begin
      e = (i % 2 == 0) ? 2'b01 : 2'b10;
      cmp_cycle(1'b1, AW'(i), e, e, 1'b0);
    end
    cmp_cycle(1'b0, 4'd0, 2'b00, 2'b00, 1'b1);
    drain_run(0);

    // two faults, ready high, then with backpressure
    two_fault_run(0);
    two_fault_run(1);

    // overflow: 6 mismatches into a 4-deep log
    start_pulse();
    for (int i = 0; i < 6; i++) cmp_cycle(1'b1, AW'(i), 2'b01, 2'b10, 1'b0);
    cmp_cycle(1'b0, 4'd0, 2'b00, 2'b00, 1'b1);
    drain_run(0);

    // mismatch in the same cycle as test_done
    start_pulse();
    cmp_cycle(1'b1, 4'd7, 2'b01, 2'b00, 1'b1);
    drain_run(0);

    // start during DRAIN discards the presented entry and the log
    start_pulse();
    cmp_cycle(1'b1, 4'd2, 2'b10, 2'b11, 1'b0);
    cmp_cycle(1'b1, 4'd4, 2'b10, 2'b01, 1'b1);
    chk("pre_restart_valid", log_valid, 1);
    log_ready = 1'b1;
    start_pulse();
    log_ready = 1'b0;
    chk("restart_addr", log_addr, 0);
    cmp_cycle(1'b1, 4'd1, 2'b01, 2'b01, 1'b1);
    drain_run(0);

    // asynchronous reset mid-CAPTURE
    start_pulse();
    cmp_cycle(1'b1, 4'd6, 2'b01, 2'b11, 1'b0);
    cmp_cycle(1'b1, 4'd8, 2'b10, 2'b11, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    model_clear();
    chk_all_zero("async_rst");
    step();
    rst_n = 1'b0;
    step();
    chk_all_zero("post_rst");

    // saturation of the fail counter
    start_pulse();
    for (int i = 0; i < 300; i++) cmp_cycle(1'b1, AW'(i % 16), 2'b10, 2'b01, 1'b0);
    cmp_cycle(1'b0, 4'd0, 2'b00, 2'b00, 1'b1);
    drain_run(2);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      start_pulse();
      n = $urandom_range(4, 30);
      for (int i = 0; i < n; i++) begin
        a = AW'($urandom_range(0, 15));
        e = (a[0] ^ r[0]) ? 2'b10 : 2'b01;
        act = e;
        if ($urandom_range(0, 3) == 0) act = e ^ DW'($urandom_range(1, 3));
        v = ($urandom_range(0, 9) < 7);
        cmp_cycle(v, a, e, act, (i == n - 1) && (r % 2 == 1));
      end
      if (r % 2 == 0) cmp_cycle(1'b0, 4'd0, 2'b00, 2'b00, 1'b1);
      drain_run(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bist_cb_fail_log.md
# bist_cb_fail_log

Fail-address capture and readout unit on the response side of the checkerboard memory BIST. It watches the compare strobe from the BIST engine during the test and logs each mismatching SRAM address with its bit syndrome (expected XOR actual) into a small buffer. After the test ends, it drains the log to the tester over a valid/ready handshake, so failures can be diagnosed per address and per bit rather than only as a single pass/fail flag.

## Interface
Parameters:
- ADDR_W, 4, SRAM address width (16 words)
- DATA_W, 2, SRAM word width
- DEPTH, 4, number of log entries; power of two, at least 2
- CNT_W, 8, width of the saturating fail counter

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-high; the polarity is fixed
- start  in  1  one-cycle pulse; clears the log and counters and begins capture
- cmp_valid  in  1  BIST read-compare strobe for this cycle
- cmp_addr  in  ADDR_W  address being compared
- cmp_expect  in  DATA_W  expected checkerboard pattern
- cmp_actual  in  DATA_W  SRAM read data
- test_done  in  1  level or pulse from the BIST engine marking the end of test
- log_valid  out  1  a log entry is presented
- log_ready  in  1  tester accepts the presented entry
- log_addr  out  ADDR_W  failing address of the head entry
- log_syn  out  DATA_W  failing-bit mask of the head entry
- fail_cnt  out  CNT_W  total mismatches seen; saturates at all-ones
- overflow  out  1  at least one mismatch was dropped because the log was full
- done  out  1  drain complete
- pass  out  1  done && fail_cnt==0

## Operation
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: all outputs 0. start moves to CAPTURE.
- CAPTURE:
  - A mismatch is a cycle with cmp_valid && (cmp_expect != cmp_actual).
  - On a mismatch, fail_cnt increments, saturating at 2^CNT_W-1.
  - If the log is not full, push {cmp_addr, cmp_expect^cmp_actual}. If it is full, set overflow (sticky) and drop the entry.
- CAPTURE on test_done moves to DRAIN. A compare in that same cycle is still captured first.
- DRAIN:
  - log_valid = !empty; log_addr and log_syn come from the head entry.
  - Pop when log_valid && log_ready.
  - Move to DONE in the cycle the log is empty and test_done has been seen. This applies immediately if no entries were logged.
- DONE: done=1. pass is valid. fail_cnt and overflow hold.
- start in any state other than IDLE restarts:
  - clear the log, fail_cnt and overflow;
  - go to CAPTURE;
  - discard any entry being presented.
- cmp_valid outside CAPTURE is ignored.
- The log is in-order (FIFO). Pointers are log2(DEPTH) bits plus a wrap bit; full and empty are derived from these.

## Timing
- All outputs are registered or come straight from registers. Reset value of every output is 0, and the state is IDLE.
- A mismatch at edge N makes the entry visible, and fail_cnt updated, after edge N. In DRAIN, that is log_valid at N+1.
- Pop at edge N presents the next entry at N+1, giving a sustained throughput of 1 entry per cycle with log_ready held high.
- log_addr and log_syn are stable while log_valid && !log_ready.
- The last pop at edge N gives log_valid=0 and done=1 after edge N.
- The DRAIN to DONE transition takes 1 cycle with an empty log.
- Asynchronous reset mid-operation returns everything to IDLE with zero outputs immediately, without waiting for a clock edge. The log contents become don't-care.

## Structure
- The shared package `bist_pkg` holds:
  - the state encoding localparams (IDLE=0, CAPTURE=1, DRAIN=2, DONE=3);
  - the ADDR_W and DATA_W defaults;
  - the log-entry packing (addr in the upper bits, syndrome in the lower bits).
- One sub-module, `bist_fail_fifo`: synchronous FIFO with parameters DEPTH and width, push/pop/flush, and full/empty outputs.
- The top level holds the FSM, the saturating counter and the overflow flag.

## Test plan
- Clean run: start, then 16 compares with expect==actual, then test_done. Required: no log_valid, done=1 one cycle later, pass=1, fail_cnt=0.
- Two faults: mismatch at addr 3 (expect 2'b01, actual 2'b11) and at addr 9 (2'b10 vs 2'b00), then test_done, with log_ready=1. Required: entries {3,2'b10} then {9,2'b10} on consecutive cycles, then done=1, pass=0, fail_cnt=2.
- Overflow: 6 mismatches at addrs 0..5 with DEPTH=4. Required: log drains addrs 0..3 only, overflow=1, fail_cnt=6.
- Backpressure: same run as the two-fault case with log_ready low for 3 cycles. Required: the addr-3 entry is held stable, with no loss and no duplicate.
- Edge cases:
  - Mismatch and test_done in the same cycle: the entry is logged.
  - start asserted during DRAIN: log cleared, fail_cnt=0, state CAPTURE.
  - rst_n pulsed mid-CAPTURE: all outputs 0 at once.
